// File: rtl/scalar_product_stream_pkg.sv
// ============================================================================
// scalar_pkg : shared types and sizing helpers for scalar_product_stream
// Revision   : 1.0
// ============================================================================
`default_nettype none

package scalar_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

  localparam int DEF_SIZE_ARRAY = 256;
  localparam int DEF_SIZE_INT   = 32;
  localparam int DEF_LANES      = 4;

  function automatic int beat_count(input int size_array, input int lanes);
    return size_array / lanes;
  endfunction

  // A single-beat vector still needs a one-bit counter to keep ranges legal.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scalar_product_stream_lane_dot_tree.sv
// ============================================================================
// lane_dot_tree : combinational LANES-wide multiply and adder-tree reduction
// Revision      : 1.0  (carry_any port exists with SCALAR_PROD_OVF_EN)
// ============================================================================
`default_nettype none

module lane_dot_tree
  import scalar_pkg::*;
#(
  parameter int SIZE_INT = DEF_SIZE_INT,
  parameter int LANES    = DEF_LANES
) (
  input  logic [LANES*SIZE_INT-1:0] x,
  input  logic [LANES*SIZE_INT-1:0] y,
  output logic [SIZE_INT-1:0]       sum
`ifdef SCALAR_PROD_OVF_EN
  ,
  output logic                      carry_any
`endif
);

  localparam int LEVELS = $clog2(LANES);

  // Level 0 holds the truncated lane products; each later level halves the count.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_level
    localparam int N = LANES >> l;
    logic [N*SIZE_INT-1:0] v;
`ifdef SCALAR_PROD_OVF_EN
    logic [N-1:0] c;
    logic         any_c;
`endif

    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_lane
`ifdef SCALAR_PROD_OVF_EN
        logic [2*SIZE_INT-1:0] p;
        assign p = {{SIZE_INT{1'b0}}, x[j*SIZE_INT +: SIZE_INT]} *
                   {{SIZE_INT{1'b0}}, y[j*SIZE_INT +: SIZE_INT]};
        assign v[j*SIZE_INT +: SIZE_INT] = p[SIZE_INT-1:0];
        assign c[j] = |p[2*SIZE_INT-1:SIZE_INT];
`else
        assign v[j*SIZE_INT +: SIZE_INT] = x[j*SIZE_INT +: SIZE_INT] *
                                           y[j*SIZE_INT +: SIZE_INT];
`endif
      end
`ifdef SCALAR_PROD_OVF_EN
      assign any_c = |c;
`endif
    end else begin : g_node
      for (genvar j = 0; j < N; j++) begin : g_pair
`ifdef SCALAR_PROD_OVF_EN
        logic [SIZE_INT:0] s;
        assign s = {1'b0, g_level[l-1].v[(2*j)*SIZE_INT +: SIZE_INT]} +
                   {1'b0, g_level[l-1].v[(2*j+1)*SIZE_INT +: SIZE_INT]};
        assign v[j*SIZE_INT +: SIZE_INT] = s[SIZE_INT-1:0];
        assign c[j] = s[SIZE_INT];
`else
        assign v[j*SIZE_INT +: SIZE_INT] = g_level[l-1].v[(2*j)*SIZE_INT +: SIZE_INT] +
                                           g_level[l-1].v[(2*j+1)*SIZE_INT +: SIZE_INT];
`endif
      end
`ifdef SCALAR_PROD_OVF_EN
      assign any_c = g_level[l-1].any_c | (|c);
`endif
    end
  end

  assign sum = g_level[LEVELS].v;
`ifdef SCALAR_PROD_OVF_EN
  assign carry_any = g_level[LEVELS].any_c;
`endif

endmodule

`default_nettype wire

// File: rtl/scalar_product_stream.sv
// ============================================================================
// scalar_product_stream : streaming dot product, LANES elements per beat
// Revision              : 1.0  (ovf port exists with SCALAR_PROD_OVF_EN)
// ============================================================================
`default_nettype none

module scalar_product_stream
  import scalar_pkg::*;
#(
  parameter int SIZE_ARRAY = DEF_SIZE_ARRAY,
  parameter int SIZE_INT   = DEF_SIZE_INT,
  parameter int LANES      = DEF_LANES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*SIZE_INT-1:0] in_x,
  input  logic [LANES*SIZE_INT-1:0] in_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SIZE_INT-1:0]       result
`ifdef SCALAR_PROD_OVF_EN
  ,
  output logic                      ovf
`endif
);

  localparam int BEATS = beat_count(SIZE_ARRAY, LANES);
  localparam int CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((LANES < 1) || ((LANES & (LANES - 1)) != 0) || ((SIZE_ARRAY % LANES) != 0))
  begin : g_param_check
    $error("scalar_product_stream: LANES must be a power of two dividing SIZE_ARRAY");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SIZE_INT-1:0] acc_q, acc_d;
  logic [SIZE_INT-1:0] result_q, result_d;
  logic [SIZE_INT-1:0] beat_sum;
  logic [SIZE_INT-1:0] acc_sum;
  logic                accept;

`ifdef SCALAR_PROD_OVF_EN
  logic tree_carry;
  logic acc_carry;
  logic ovf_flag_q, ovf_flag_d;
  logic ovf_q, ovf_d;
  logic ovf_any;
`endif

  lane_dot_tree #(
    .SIZE_INT (SIZE_INT),
    .LANES    (LANES)
  ) u_tree (
    .x         (in_x),
    .y         (in_y),
    .sum       (beat_sum)
`ifdef SCALAR_PROD_OVF_EN
    ,
    .carry_any (tree_carry)
`endif
  );

`ifdef SCALAR_PROD_OVF_EN
  assign {acc_carry, acc_sum} = {1'b0, acc_q} + {1'b0, beat_sum};
  assign ovf_any = ovf_flag_q | tree_carry | acc_carry;
`else
  assign acc_sum = acc_q + beat_sum;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_q;
    in_ready  = (state_q == ACC);
    out_valid = (state_q == DONE);
    accept    = in_valid && in_ready;
`ifdef SCALAR_PROD_OVF_EN
    ovf_flag_d = ovf_flag_q;
    ovf_d      = ovf_q;
`endif
    case (state_q)
      ACC: begin
        if (accept) begin
          if (cnt_q == LAST_BEAT) begin
            result_d = acc_sum;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = DONE;
`ifdef SCALAR_PROD_OVF_EN
            ovf_d      = ovf_any;
            ovf_flag_d = 1'b0;
`endif
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
`ifdef SCALAR_PROD_OVF_EN
            ovf_flag_d = ovf_any;
`endif
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACC;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
`ifdef SCALAR_PROD_OVF_EN
      ovf_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
`ifdef SCALAR_PROD_OVF_EN
      ovf_flag_q <= ovf_flag_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign result = result_q;
`ifdef SCALAR_PROD_OVF_EN
  assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_scalar_product_stream.sv
// ============================================================================
// tb_scalar_product_stream : scenario bench for scalar_product_stream
// Revision                 : 1.0
// ============================================================================
`default_nettype none

module tb_scalar_product_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut_a: 8 elements, 4 lanes -> two beats per vector
  logic         in_valid_a = 1'b0;
  logic         in_ready_a;
  logic [127:0] in_x_a = '0;
  logic [127:0] in_y_a = '0;
  logic         out_valid_a;
  logic         out_ready_a = 1'b1;
  logic [31:0]  result_a;
  // dut_b: 4 elements, 1 lane -> four beats per vector
  logic         in_valid_b = 1'b0;
  logic         in_ready_b;
  logic [31:0]  in_x_b = '0;
  logic [31:0]  in_y_b = '0;
  logic         out_valid_b;
  logic         out_ready_b = 1'b1;
  logic [31:0]  result_b;
`ifdef SCALAR_PROD_OVF_EN
  logic         ovf_a;
  logic         ovf_b;
`endif

  scalar_product_stream #(.SIZE_ARRAY(8), .SIZE_INT(32), .LANES(4)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .in_x      (in_x_a),
    .in_y      (in_y_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .result    (result_a)
`ifdef SCALAR_PROD_OVF_EN
    ,
    .ovf       (ovf_a)
`endif
  );

  scalar_product_stream #(.SIZE_ARRAY(4), .SIZE_INT(32), .LANES(1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_x      (in_x_b),
    .in_y      (in_y_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .result    (result_b)
`ifdef SCALAR_PROD_OVF_EN
    ,
    .ovf       (ovf_b)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] expv;

  function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat to dut_a and return just after the edge that accepts it.
  task automatic drive_beat_a(input logic [127:0] x, input logic [127:0] y);
    bit ok;
    ok = 1'b0;
    in_valid_a = 1'b1;
    in_x_a     = x;
    in_y_a     = y;
    for (int budget = 0; budget < 20 && !ok; budget++) begin
      if (in_ready_a) ok = 1'b1;
      tick();
    end
    in_valid_a = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL beat_accept_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_a: got %b want 1", in_ready_a); end
    n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_a: got %b want 0", out_valid_a); end
    n_checks++; if (result_a !== 32'd0) begin n_fail++; $display("FAIL reset_result_a: got %0d want 0", result_a); end
    n_checks++; if (in_ready_b !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_b: got %b want 1", in_ready_b); end
    n_checks++; if (out_valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_b: got %b want 0", out_valid_b); end
`ifdef SCALAR_PROD_OVF_EN
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_a: got %b want 0", ovf_a); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    out_ready_a = 1'b1;
    exp_a.push_back(32'd36);
    drive_beat_a(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1));
    n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL basic_mid_valid: got %b want 0", out_valid_a); end
    drive_beat_a(pack4(5, 6, 7, 8), pack4(1, 1, 1, 1));
    expv = exp_a.pop_front();
    n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b want 1", out_valid_a); end
    n_checks++; if (result_a !== expv) begin n_fail++; $display("FAIL basic_result: got %0d want %0d", result_a, expv); end
`ifdef SCALAR_PROD_OVF_EN
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", ovf_a); end
`endif
    tick();
    n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b want 0", out_valid_a); end
  endtask

  task automatic test_backpressure();
    out_ready_a = 1'b0;
    exp_a.push_back(32'd204);
    drive_beat_a(pack4(1, 2, 3, 4), pack4(1, 2, 3, 4));
    drive_beat_a(pack4(5, 6, 7, 8), pack4(5, 6, 7, 8));
    // Next vector is already offered while the result is held.
    in_valid_a = 1'b1;
    in_x_a     = pack4(1, 1, 1, 1);
    in_y_a     = pack4(1, 1, 1, 1);
    exp_a.push_back(32'd8);
    expv = exp_a.pop_front();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid_a); end
      n_checks++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready_a); end
      n_checks++; if (result_a !== expv) begin n_fail++; $display("FAIL hold_result[%0d]: got %0d want %0d", i, result_a, expv); end
      tick();
    end
    out_ready_a = 1'b1;
    n_checks++; if (result_a !== expv) begin n_fail++; $display("FAIL release_result: got %0d want %0d", result_a, expv); end
    tick();
    n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b want 0", out_valid_a); end
    n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready_a); end
    drive_beat_a(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    drive_beat_a(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    expv = exp_a.pop_front();
    n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL next_vec_valid: got %b want 1", out_valid_a); end
    n_checks++; if (result_a !== expv) begin n_fail++; $display("FAIL next_vec_result: got %0d want %0d", result_a, expv); end
    tick();
  endtask

  task automatic test_overflow();
    exp_a.push_back(32'd0);
    drive_beat_a(pack4(32'h0001_0000, 0, 0, 0), pack4(32'h0001_0000, 0, 0, 0));
    drive_beat_a(pack4(0, 0, 0, 0), pack4(0, 0, 0, 0));
    expv = exp_a.pop_front();
    n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL ovf_vec_valid: got %b want 1", out_valid_a); end
    n_checks++; if (result_a !== expv) begin n_fail++; $display("FAIL ovf_vec_result: got %0d want %0d", result_a, expv); end
`ifdef SCALAR_PROD_OVF_EN
    n_checks++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf_a); end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    drive_beat_a(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready_a); end
    exp_a.push_back(32'd48);
    drive_beat_a(pack4(2, 2, 2, 2), pack4(3, 3, 3, 3));
    drive_beat_a(pack4(2, 2, 2, 2), pack4(3, 3, 3, 3));
    expv = exp_a.pop_front();
    n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 1", out_valid_a); end
    n_checks++; if (result_a !== expv) begin n_fail++; $display("FAIL rst_mid_result: got %0d want %0d", result_a, expv); end
`ifdef SCALAR_PROD_OVF_EN
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovf: got %b want 0", ovf_a); end
`endif
    tick();
    // Reset while a result is pending drops it.
    out_ready_a = 1'b0;
    drive_beat_a(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    drive_beat_a(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL rst_done_pre: got %b want 1", out_valid_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready_a = 1'b1;
    n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_done_valid: got %b want 0", out_valid_a); end
    n_checks++; if (result_a !== 32'd0) begin n_fail++; $display("FAIL rst_done_result: got %0d want 0", result_a); end
  endtask

  task automatic test_gaps();
    exp_a.push_back(32'd56);
    drive_beat_a(pack4(1, 1, 1, 1), pack4(7, 7, 7, 7));
    in_x_a = {4{32'hFFFF_FFFF}};
    in_y_a = {4{32'h1234_5678}};
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL gap_valid[%0d]: got %b want 0", i, out_valid_a); end
    end
    drive_beat_a(pack4(1, 1, 1, 1), pack4(7, 7, 7, 7));
    expv = exp_a.pop_front();
    n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL gap_out_valid: got %b want 1", out_valid_a); end
    n_checks++; if (result_a !== expv) begin n_fail++; $display("FAIL gap_result: got %0d want %0d", result_a, expv); end
    tick();
  endtask

  task automatic test_single_lane();
    exp_b.push_back(32'd30);
    in_valid_b = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_x_b = 32'(k);
      in_y_b = 32'(k);
      n_checks++; if (in_ready_b !== 1'b1) begin n_fail++; $display("FAIL lane1_in_ready[%0d]: got %b want 1", k, in_ready_b); end
      tick();
      if (k < 4) begin
        n_checks++; if (out_valid_b !== 1'b0) begin n_fail++; $display("FAIL lane1_early_valid[%0d]: got %b want 0", k, out_valid_b); end
      end
    end
    in_valid_b = 1'b0;
    expv = exp_b.pop_front();
    n_checks++; if (out_valid_b !== 1'b1) begin n_fail++; $display("FAIL lane1_out_valid: got %b want 1", out_valid_b); end
    n_checks++; if (result_b !== expv) begin n_fail++; $display("FAIL lane1_result: got %0d want %0d", result_b, expv); end
`ifdef SCALAR_PROD_OVF_EN
    n_checks++; if (ovf_b !== 1'b0) begin n_fail++; $display("FAIL lane1_ovf: got %b want 0", ovf_b); end
`endif
    tick();
    n_checks++; if (out_valid_b !== 1'b0) begin n_fail++; $display("FAIL lane1_one_cycle: got %b want 0", out_valid_b); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_gaps();
    test_single_lane();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
